branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised successor to the single-cycle branch decision logic, for the pipelined core. It predicts branch direction at fetch from a table of 2-bit saturating counters indexed by PC, resolves the actual branch in EX with an extended condition set, and trains the table. It raises a registered flush when a prediction was wrong and keeps saturating branch and mispredict counters for performance monitoring.

## Interface
Parameters:
- REG_BITS, 32, operand and PC width
- ENTRIES, 64, predictor table depth; power of two, at least 2
- CNT_BITS, 16, width of each performance counter

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_pc  in  REG_BITS  PC being fetched
- pred_taken  out  1  combinational prediction for fetch_pc
- res_valid  in  1  EX stage holds a valid instruction this cycle
- res_pc  in  REG_BITS  PC of the EX instruction
- PCSrc  in  2  00 none, 01 conditional, 10 unconditional, 11 treated as none
- opcode2  in  3  condition select when PCSrc=01
- operand  in  REG_BITS  value tested, two's complement
- res_pred  in  1  pred_taken value carried down the pipeline with this instruction
- branch  out  1  combinational actual-taken decision for EX
- flush  out  1  registered mispredict pulse
- flush_taken  out  1  registered copy of branch, valid while flush=1
- branch_cnt  out  CNT_BITS  resolved branches (PCSrc 01 or 10)
- mispred_cnt  out  CNT_BITS  mispredictions

## Operation
- Index: idx = pc[log2(ENTRIES)+1:2] (word-aligned PCs). The same function is used for fetch_pc and res_pc.
- pred_taken = table[idx(fetch_pc)][1].
- branch is forced to 0 when res_valid=0.
- branch for PCSrc: 10 gives 1; 00 and 11 give 0.
- branch for PCSrc=01, by opcode2:
  - 000: operand==0
  - 001: operand!=0
  - 010: operand<0
  - 011: operand>=0
  - 100: operand>0
  - 101: operand<=0
  - 110, 111: 0
- A resolved branch is res_valid & (PCSrc==01 | PCSrc==10).
- Training, on a resolved branch only: table[idx(res_pc)] increments when branch=1 and saturates at 11; it decrements when branch=0 and saturates at 00. Non-branches leave the table untouched.
- Mispredict = resolved branch & (branch != res_pred). Non-branch instructions never mispredict, even when res_pred=1.
- branch_cnt increments on each resolved branch. mispred_cnt increments on each mispredict. Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, immediate):
  - every table entry = 01 (weakly not-taken), so pred_taken=0 everywhere
  - flush=0, flush_taken=0, branch_cnt=0, mispred_cnt=0
- pred_taken and branch: zero-latency combinational.
- Table write, counter increments and flush all take effect at the clock edge that samples the resolution. flush is high exactly the following cycle, one cycle wide per mispredict. Back-to-back mispredicts give back-to-back flush cycles.
- Same-cycle lookup and update of the same index: pred_taken returns the pre-update value. No bypass.
- The cycle after flush, the pipeline supplies res_valid=0 or a new instruction. The block keeps no memory of the flushed instruction.
- rst asserted mid-operation clears a pending flush in the same cycle. A table write at that edge is discarded.

## Structure
- Shared package (branch_pkg):
  - PCSrc encodings PCSRC_NONE, PCSRC_COND, PCSRC_UNCOND
  - opcode2 condition encodings BR_Z, BR_NZ, BR_LT, BR_GE, BR_GT, BR_LE
  - counter constants SC_SNT=00, SC_WNT=01, SC_WT=10, SC_ST=11
- One natural sub-module: branch_cond_eval, the combinational PCSrc/opcode2/operand to branch decision, reusable by the single-cycle core.
- The table is a flop array of ENTRIES x 2 bits, not inferred RAM, because of the asynchronous reset.

## Test plan
- Reset, then fetch_pc=0x40 -> pred_taken=0; flush=0; both counters 0.
- PCSrc=01, opcode2=000, operand=0, res_pc=0x40, res_pred=0, repeated three times:
  - branch=1 each time; flush on each of the three following cycles
  - the entry steps 01→10→11; pred_taken for 0x40 becomes 1 after the first update
  - branch_cnt=3, mispred_cnt=3
- Condition sweep, operand ∈ {0x80000000, 0xFFFFFFFF, 0, 1, 0x7FFFFFFF} across opcode2 000–111 -> branch matches the signed table. Examples: opcode2=100 with operand=0xFFFFFFFF gives 0; opcode2=011 with operand=0 gives 1.
- Aliasing: with ENTRIES=64, train 0x40 to 11, then fetch 0x140 -> pred_taken=1. A resolution at 0x140 with branch=0 moves the shared entry to 10.
- Same index updated and fetched in one cycle -> pred_taken shows the old value, then the new value next cycle. rst asserted during a flush cycle -> flush drops immediately and the table returns to 01.
- Saturation: CNT_BITS=4, 20 mispredicting branches -> both counters hold at 15. PCSrc=11 or res_valid=0 -> no count, no table change, no flush.

Source files
------------

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared encodings for branch resolution and prediction:
//               PCSrc kinds, conditional-branch condition selects, and
//               2-bit saturating counter states with their update helper.
// Revision    : 1.0  initial release
// ============================================================================
package branch_pkg;

    // PCSrc encodings (2'b11 behaves like PCSRC_NONE)
    localparam logic [1:0] PCSRC_NONE   = 2'b00;
    localparam logic [1:0] PCSRC_COND   = 2'b01;
    localparam logic [1:0] PCSRC_UNCOND = 2'b10;

    // opcode2 condition selects for conditional branches (110/111 never taken)
    localparam logic [2:0] BR_Z  = 3'b000;
    localparam logic [2:0] BR_NZ = 3'b001;
    localparam logic [2:0] BR_LT = 3'b010;
    localparam logic [2:0] BR_GE = 3'b011;
    localparam logic [2:0] BR_GT = 3'b100;
    localparam logic [2:0] BR_LE = 3'b101;

    // 2-bit saturating counter states; MSB is the predicted direction
    localparam logic [1:0] SC_SNT = 2'b00;
    localparam logic [1:0] SC_WNT = 2'b01;
    localparam logic [1:0] SC_WT  = 2'b10;
    localparam logic [1:0] SC_ST  = 2'b11;

    // Step a counter toward the observed direction, holding at the ends
    function automatic logic [1:0] sc_update(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken && (cur != SC_ST)) begin
            nxt = cur + 2'b01;
        end else if (!taken && (cur != SC_SNT)) begin
            nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Combinational branch decision from PCSrc, opcode2 and a
//               two's-complement operand. No valid qualification here so
//               the single-cycle core can reuse it directly.
// Ports       : PCSrc      in  2         branch kind
//               opcode2    in  3         condition select for PCSRC_COND
//               operand    in  REG_BITS  value under test (signed)
//               cond_taken out 1         branch taken
// Revision    : 1.0  initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int REG_BITS = 32
) (
    input  logic [1:0]          PCSrc,
    input  logic [2:0]          opcode2,
    input  logic [REG_BITS-1:0] operand,
    output logic                cond_taken
);

    logic w_zero;
    logic w_neg;
    logic w_cond;

    assign w_zero = (operand == '0);
    assign w_neg  = operand[REG_BITS-1];

    always_comb begin
        w_cond = 1'b0;
        case (opcode2)
            BR_Z:    w_cond = w_zero;
            BR_NZ:   w_cond = !w_zero;
            BR_LT:   w_cond = w_neg;
            BR_GE:   w_cond = !w_neg;
            BR_GT:   w_cond = !w_neg && !w_zero;
            BR_LE:   w_cond = w_neg || w_zero;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        cond_taken = 1'b0;
        case (PCSrc)
            PCSRC_COND:   cond_taken = w_cond;
            PCSRC_UNCOND: cond_taken = 1'b1;
            default:      cond_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-time direction predictor built from a PC-indexed table
//               of 2-bit saturating counters, with EX-stage resolution,
//               table training, a registered mispredict flush and saturating
//               branch / mispredict performance counters.
// Ports       : clk, rst         clock, asynchronous active-high reset
//               fetch_pc         in   PC being fetched
//               pred_taken       out  combinational prediction for fetch_pc
//               res_valid        in   EX holds a valid instruction
//               res_pc           in   PC of the EX instruction
//               PCSrc, opcode2   in   branch kind / condition select
//               operand          in   value tested by the condition
//               res_pred         in   prediction carried with the instruction
//               branch           out  combinational actual-taken decision
//               flush            out  registered mispredict pulse
//               flush_taken      out  registered branch, valid with flush
//               branch_cnt       out  resolved branch count (saturating)
//               mispred_cnt      out  mispredict count (saturating)
// Revision    : 1.0  initial release
// ============================================================================
module branch_predictor
    import branch_pkg::*;
#(
    parameter int REG_BITS = 32,
    parameter int ENTRIES  = 64,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] fetch_pc,
    output logic                pred_taken,
    input  logic                res_valid,
    input  logic [REG_BITS-1:0] res_pc,
    input  logic [1:0]          PCSrc,
    input  logic [2:0]          opcode2,
    input  logic [REG_BITS-1:0] operand,
    input  logic                res_pred,
    output logic                branch,
    output logic                flush,
    output logic                flush_taken,
    output logic [CNT_BITS-1:0] branch_cnt,
    output logic [CNT_BITS-1:0] mispred_cnt
);

    localparam int c_IDX_BITS = $clog2(ENTRIES);

    // Flop array rather than RAM: every entry must clear on async reset
    logic [1:0]            r_table [ENTRIES];
    logic [c_IDX_BITS-1:0] w_fetch_idx;
    logic [c_IDX_BITS-1:0] w_res_idx;
    logic                  w_cond_taken;
    logic                  w_resolved;
    logic                  w_mispred;
    logic                  r_flush;
    logic                  r_flush_taken;
    logic [CNT_BITS-1:0]   r_branch_cnt;
    logic [CNT_BITS-1:0]   r_mispred_cnt;
    logic                  w_unused_pc_bits;

    // Word-aligned PCs: skip the byte offset, use the next log2(ENTRIES) bits
    assign w_fetch_idx = fetch_pc[c_IDX_BITS+1:2];
    assign w_res_idx   = res_pc[c_IDX_BITS+1:2];

    assign w_unused_pc_bits = ^{fetch_pc[1:0], fetch_pc[REG_BITS-1:c_IDX_BITS+2],
                                res_pc[1:0],   res_pc[REG_BITS-1:c_IDX_BITS+2]};

    branch_cond_eval #(
        .REG_BITS (REG_BITS)
    ) u_cond (
        .PCSrc      (PCSrc),
        .opcode2    (opcode2),
        .operand    (operand),
        .cond_taken (w_cond_taken)
    );

    assign branch     = res_valid && w_cond_taken;
    assign w_resolved = res_valid && ((PCSrc == PCSRC_COND) || (PCSrc == PCSRC_UNCOND));
    // Non-branches never mispredict, whatever res_pred says
    assign w_mispred  = w_resolved && (branch != res_pred);

    // Read is from the registered table, so a same-cycle update to the
    // fetched index is not visible until the next cycle
    assign pred_taken = r_table[w_fetch_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= SC_WNT;
            end
        end else if (w_resolved) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_res_idx == c_IDX_BITS'(i)) begin
                    r_table[i] <= sc_update(r_table[i], branch);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush       <= 1'b0;
            r_flush_taken <= 1'b0;
        end else begin
            r_flush       <= w_mispred;
            r_flush_taken <= branch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolved && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_BITS'(1);
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_BITS'(1);
            end
        end
    end

    assign flush       = r_flush;
    assign flush_taken = r_flush_taken;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor (ENTRIES=64,
//               CNT_BITS=4) against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [1:0]  PCSrc;
    logic [2:0]  opcode2;
    logic [31:0] operand;
    logic        res_pred;
    logic        branch;
    logic        flush;
    logic        flush_taken;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    int checks;
    int errors;

    // Reference model state
    int m_table [64];
    int m_bcnt;
    int m_mcnt;
    bit m_flush;
    bit m_flush_taken;

    branch_predictor #(
        .REG_BITS (32),
        .ENTRIES  (64),
        .CNT_BITS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_pc    (fetch_pc),
        .pred_taken  (pred_taken),
        .res_valid   (res_valid),
        .res_pc      (res_pc),
        .PCSrc       (PCSrc),
        .opcode2     (opcode2),
        .operand     (operand),
        .res_pred    (res_pred),
        .branch      (branch),
        .flush       (flush),
        .flush_taken (flush_taken),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic bit m_cond(input logic [1:0] src, input logic [2:0] op,
                                  input logic [31:0] v);
        int s;
        s = v;
        if (src == 2'd2) return 1'b1;
        if (src != 2'd1) return 1'b0;
        case (op)
            3'd0:    return s == 0;
            3'd1:    return s != 0;
            3'd2:    return s < 0;
            3'd3:    return s >= 0;
            3'd4:    return s > 0;
            3'd5:    return s <= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_table[i] = 1;
        m_bcnt        = 0;
        m_mcnt        = 0;
        m_flush       = 1'b0;
        m_flush_taken = 1'b0;
    endtask

    // One EX/fetch cycle: drive, check combinational outputs against the
    // pre-update model, advance the model, clock, check registered outputs.
    task automatic do_cycle(input bit v, input logic [31:0] rpc, input logic [1:0] src,
                            input logic [2:0] op, input logic [31:0] opnd,
                            input bit rp, input logic [31:0] fpc);
        bit exp_br;
        bit resolved;
        bit mis;
        int k;
        res_valid = v;
        res_pc    = rpc;
        PCSrc     = src;
        opcode2   = op;
        operand   = opnd;
        res_pred  = rp;
        fetch_pc  = fpc;
        #1;
        check_eq("pred_taken", pred_taken, (m_table[m_idx(fpc)] >= 2) ? 1 : 0);
        exp_br = v && m_cond(src, op, opnd);
        check_eq("branch", branch, exp_br);
        resolved = v && (src == 2'd1 || src == 2'd2);
        mis      = resolved && (exp_br != rp);
        if (resolved) begin
            k = m_idx(rpc);
            if (exp_br) m_table[k] = (m_table[k] < 3) ? m_table[k] + 1 : 3;
            else        m_table[k] = (m_table[k] > 0) ? m_table[k] - 1 : 0;
            m_bcnt = (m_bcnt < 15) ? m_bcnt + 1 : 15;
        end
        if (mis) m_mcnt = (m_mcnt < 15) ? m_mcnt + 1 : 15;
        m_flush       = mis;
        m_flush_taken = exp_br;
        @(posedge clk);
        #1;
        check_eq("flush", flush, m_flush);
        if (m_flush) check_eq("flush_taken", flush_taken, m_flush_taken);
        check_eq("branch_cnt", branch_cnt, m_bcnt);
        check_eq("mispred_cnt", mispred_cnt, m_mcnt);
    endtask

    logic [31:0] sweep_ops [5];

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        fetch_pc  = 32'h40;
        res_valid = 1'b0;
        res_pc    = '0;
        PCSrc     = 2'b00;
        opcode2   = 3'b000;
        operand   = '0;
        res_pred  = 1'b0;
        m_reset();
        sweep_ops[0] = 32'h8000_0000;
        sweep_ops[1] = 32'hFFFF_FFFF;
        sweep_ops[2] = 32'h0000_0000;
        sweep_ops[3] = 32'h0000_0001;
        sweep_ops[4] = 32'h7FFF_FFFF;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_pred", pred_taken, 0);
        check_eq("rst_flush", flush, 0);
        check_eq("rst_bcnt", branch_cnt, 0);
        check_eq("rst_mcnt", mispred_cnt, 0);
        @(posedge clk);
        #1;

        // Three taken BEQZ at 0x40 predicted not-taken; same-index fetch
        for (int n = 0; n < 3; n++)
            do_cycle(1, 32'h40, 2'b01, 3'b000, 32'h0, 0, 32'h40);
        check_eq("train_entry_st", pred_taken, 1);

        // Condition sweep across signed boundaries and all selects
        for (int o = 0; o < 8; o++)
            for (int j = 0; j < 5; j++)
                do_cycle(1, {$urandom_range(0, 255), 2'b00}, 2'b01, 3'(o), sweep_ops[j],
                         1'($urandom), {$urandom_range(0, 255), 2'b00});

        // Aliasing: 0x140 shares the entry of 0x40
        m_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int n = 0; n < 2; n++)
            do_cycle(1, 32'h40, 2'b10, 3'b000, 32'h0, 1, 32'h0);
        do_cycle(0, 32'h0, 2'b00, 3'b000, 32'h0, 0, 32'h140);
        check_eq("alias_pred", pred_taken, 1);
        do_cycle(1, 32'h140, 2'b01, 3'b000, 32'h1, 1, 32'h140);
        do_cycle(0, 32'h0, 2'b00, 3'b000, 32'h0, 0, 32'h40);

        // Reset during a flush cycle
        do_cycle(1, 32'h80, 2'b10, 3'b000, 32'h0, 0, 32'h80);
        do_cycle(1, 32'h80, 2'b10, 3'b000, 32'h0, 0, 32'h80);
        res_valid = 1'b0;
        rst = 1'b1;
        #1;
        m_reset();
        check_eq("rst_mid_flush", flush, 0);
        check_eq("rst_mid_pred", pred_taken, 0);
        check_eq("rst_mid_bcnt", branch_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-branches never count, train or flush
        do_cycle(1, 32'h80, 2'b11, 3'b000, 32'h0, 1, 32'h80);
        do_cycle(0, 32'h80, 2'b10, 3'b000, 32'h0, 0, 32'h80);
        do_cycle(1, 32'h80, 2'b00, 3'b000, 32'h0, 1, 32'h80);

        // Randomized mix over a small PC window to provoke index collisions
        for (int n = 0; n < 400; n++)
            do_cycle(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 127), 2'b00},
                     2'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                     1'($urandom), {$urandom_range(0, 127), 2'b00});

        // Saturation of both counters
        m_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int n = 0; n < 20; n++)
            do_cycle(1, 32'h100, 2'b10, 3'b000, 32'h0, 0, 32'h100);
        check_eq("sat_bcnt", branch_cnt, 15);
        check_eq("sat_mcnt", mispred_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
